// File: rtl/sprite_descriptor_writer.sv
// Double-buffered sprite descriptor: game updates land in a shadow and reach the VGA side only at vsync.
// Optional macro ANIM_CYCLE_EN adds frame-stepped animation of the sprite ROM base address.
module sprite_descriptor_writer #(
  parameter int SPRITE_W   = 64,
  parameter int SPRITE_H   = 64,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8
) (
  input  logic        iVGA_CLK,
  input  logic        iRST,
  input  logic        iVS,
  input  logic        iUpdValid,
  output logic        oUpdReady,
  input  logic [9:0]  iX,
  input  logic [8:0]  iY,
  input  logic        iFacing,
  input  logic        iVisible,
  input  logic        iAnimRestart,
  output logic [63:0] oSpriteVGA,
  output logic        oFrameTick
);

  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [9:0] W_FIELD = 10'(SPRITE_W);
  localparam logic [8:0] H_FIELD = 9'(SPRITE_H);

  state_t      state;
  logic        vs_d;
  logic        frame_edge;
  logic [9:0]  sh_x;
  logic [8:0]  sh_y;
  logic        sh_facing;
  logic        sh_visible;
  logic        on_screen;
  logic [18:0] frame_base;

  assign frame_edge = vs_d & ~iVS;
  assign oUpdReady  = (state == IDLE) & ~iRST;
  assign on_screen  = (sh_x < 10'd640) && (sh_y < 9'd480);

`ifdef ANIM_CYCLE_EN
  logic       sh_restart;
  logic [3:0] anim_frame;
  logic [3:0] next_frame;
  logic [7:0] anim_div;
  logic [7:0] next_div;

  // Animation state as it will stand after this frame edge; a committed restart wins over stepping.
  always_comb begin
    next_frame = anim_frame;
    next_div   = anim_div;
    if (state == PENDING && sh_restart) begin
      next_frame = 4'd0;
      next_div   = 8'd0;
    end else if (anim_div == 8'(FRAME_DIV - 1)) begin
      next_div   = 8'd0;
      next_frame = (anim_frame == 4'(NUM_FRAMES - 1)) ? 4'd0 : anim_frame + 4'd1;
    end else begin
      next_div   = anim_div + 8'd1;
    end
    frame_base = 19'(BASE_ADDR + int'(next_frame) * SPRITE_W * SPRITE_H);
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      anim_frame <= 4'd0;
      anim_div   <= 8'd0;
    end else if (frame_edge) begin
      anim_frame <= next_frame;
      anim_div   <= next_div;
    end
  end
`else
  logic unused_restart;
  assign unused_restart = iAnimRestart;
  assign frame_base     = 19'(BASE_ADDR);
`endif

  // Shadow capture and commit; the descriptor only moves on a vsync falling edge.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      vs_d       <= 1'b1;
      sh_x       <= '0;
      sh_y       <= '0;
      sh_facing  <= 1'b0;
      sh_visible <= 1'b0;
`ifdef ANIM_CYCLE_EN
      sh_restart <= 1'b0;
`endif
      oSpriteVGA <= '0;
      oFrameTick <= 1'b0;
    end else begin
      vs_d       <= iVS;
      oFrameTick <= frame_edge;
      if (frame_edge) begin
        oSpriteVGA[44:35] <= W_FIELD;
        oSpriteVGA[34:26] <= H_FIELD;
        oSpriteVGA[25:7]  <= frame_base;
      end
      case (state)
        IDLE: begin
          if (iUpdValid) begin
            sh_x       <= iX;
            sh_y       <= iY;
            sh_facing  <= iFacing;
            sh_visible <= iVisible;
`ifdef ANIM_CYCLE_EN
            sh_restart <= iAnimRestart;
`endif
            state      <= PENDING;
          end
        end
        PENDING: begin
          if (frame_edge) begin
            oSpriteVGA[63:54] <= sh_x;
            oSpriteVGA[53:45] <= sh_y;
            oSpriteVGA[6]     <= sh_facing;
            oSpriteVGA[5]     <= sh_visible & on_screen;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_descriptor_writer.sv
// Randomised bench for sprite_descriptor_writer against a frame-level descriptor model, plus pinned literal cases.
module tb_sprite_descriptor_writer;

  localparam int SPRITE_W   = 64;
  localparam int SPRITE_H   = 64;
  localparam int BASE_ADDR  = 0;
  localparam int NUM_FRAMES = 4;
  localparam int FRAME_DIV  = 8;

  logic        iVGA_CLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iVS = 1'b1;
  logic        iUpdValid = 1'b0;
  logic        oUpdReady;
  logic [9:0]  iX = '0;
  logic [8:0]  iY = '0;
  logic        iFacing = 1'b0;
  logic        iVisible = 1'b0;
  logic        iAnimRestart = 1'b0;
  logic [63:0] oSpriteVGA;
  logic        oFrameTick;

  int tests = 0;
  int fails = 0;
  bit compare_en = 1'b0;

  sprite_descriptor_writer #(
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .BASE_ADDR(BASE_ADDR),
    .NUM_FRAMES(NUM_FRAMES), .FRAME_DIV(FRAME_DIV)
  ) dut (
    .iVGA_CLK(iVGA_CLK), .iRST(iRST), .iVS(iVS), .iUpdValid(iUpdValid),
    .oUpdReady(oUpdReady), .iX(iX), .iY(iY), .iFacing(iFacing),
    .iVisible(iVisible), .iAnimRestart(iAnimRestart),
    .oSpriteVGA(oSpriteVGA), .oFrameTick(oFrameTick)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  // Model: what the VGA side should see, tracked per frame edge rather than per register.
  bit          m_prev_vs;
  bit          m_pending;
  bit          m_tick;
  int          m_edges;
  logic [9:0]  m_sx;
  logic [8:0]  m_sy;
  bit          m_sf, m_sv, m_sr;
  logic [63:0] m_desc;

  function automatic logic [18:0] modelBase(input int edges);
    longint frame;
    longint addr;
`ifdef ANIM_CYCLE_EN
    frame = longint'((edges / FRAME_DIV) % NUM_FRAMES);
`else
    frame = 0;
`endif
    addr = (longint'(BASE_ADDR) + frame * SPRITE_W * SPRITE_H) % 524288;
    return 19'(addr);
  endfunction

  always @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      m_prev_vs = 1'b1;
      m_pending = 1'b0;
      m_tick    = 1'b0;
      m_edges   = 0;
      m_desc    = '0;
      m_sx = '0; m_sy = '0; m_sf = 0; m_sv = 0; m_sr = 0;
    end else begin
      bit was_pending;
      was_pending = m_pending;
      m_tick = m_prev_vs && !iVS;
      if (m_tick) begin
        if (was_pending && m_sr) m_edges = 0;
        else m_edges = m_edges + 1;
        m_desc[44:35] = 10'(SPRITE_W);
        m_desc[34:26] = 9'(SPRITE_H);
        m_desc[25:7]  = modelBase(m_edges);
        if (was_pending) begin
          m_desc[63:54] = m_sx;
          m_desc[53:45] = m_sy;
          m_desc[6]     = m_sf;
          m_desc[5]     = m_sv && (m_sx < 640) && (m_sy < 480);
          m_pending     = 1'b0;
        end
      end
      if (!was_pending && iUpdValid) begin
        m_sx = iX; m_sy = iY; m_sf = iFacing; m_sv = iVisible;
`ifdef ANIM_CYCLE_EN
        m_sr = iAnimRestart;
`else
        m_sr = 1'b0;
`endif
        m_pending = 1'b1;
      end
      m_prev_vs = iVS;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge iVGA_CLK) begin
    if (compare_en) begin
      checkOutput("desc", oSpriteVGA, m_desc);
      checkOutput("tick", 64'(oFrameTick), 64'(m_tick));
      checkOutput("ready", 64'(oUpdReady), 64'(!iRST && !m_pending));
    end
  end

  task automatic applyStimulus(input bit rst, input bit vs, input bit valid,
                               input int x, input int y, input bit facing,
                               input bit vis, input bit restart);
    @(negedge iVGA_CLK);
    #1;
    iRST = rst; iVS = vs; iUpdValid = valid;
    iX = 10'(x); iY = 9'(y); iFacing = facing; iVisible = vis; iAnimRestart = restart;
  endtask

  task automatic idle(input bit vs);
    applyStimulus(1'b0, vs, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doFrames(input int n);
    for (int i = 0; i < n; i++) begin
      idle(1'b0);
      idle(1'b1);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
  endtask

  initial begin
    bit tick_seen;
    bit vs_val;
    int vs_left;
    doReset();
    compare_en = 1'b1;

    // Quiet vsync: nothing may move
    tick_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idle(1'b1);
      if (oFrameTick) tick_seen = 1'b1;
    end
    checkOutput("quiet_desc", oSpriteVGA, 64'd0);
    checkOutput("quiet_ready", 64'(oUpdReady), 64'd1);
    checkOutput("quiet_tick", 64'(tick_seen), 64'd0);

    // Mid-frame update, committed on the next vsync fall
    applyStimulus(1'b0, 1'b1, 1'b1, 100, 200, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    checkOutput("upd_ready_low", 64'(oUpdReady), 64'd0);
    checkOutput("upd_desc_held", oSpriteVGA, 64'd0);
    idle(1'b0);
    idle(1'b1);
    checkOutput("upd_x", 64'(oSpriteVGA[63:54]), 64'd100);
    checkOutput("upd_y", 64'(oSpriteVGA[53:45]), 64'd200);
    checkOutput("upd_flags", 64'(oSpriteVGA[6:5]), 64'd3);
    checkOutput("upd_tick", 64'(oFrameTick), 64'd1);
    idle(1'b1);
    checkOutput("upd_tick_once", 64'(oFrameTick), 64'd0);

    // Second offer while pending is refused; it goes in after the commit
    applyStimulus(1'b0, 1'b1, 1'b1, 10, 20, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 30, 40, 1'b0, 1'b1, 1'b0);
    checkOutput("second_refused", 64'(oUpdReady), 64'd0);
    doFrames(1);
    checkOutput("first_commit_x", 64'(oSpriteVGA[63:54]), 64'd10);
    applyStimulus(1'b0, 1'b1, 1'b1, 30, 40, 1'b0, 1'b1, 1'b0);
    doFrames(1);
    checkOutput("second_commit_x", 64'(oSpriteVGA[63:54]), 64'd30);

    // Off-screen x keeps its value but is not visible
    applyStimulus(1'b0, 1'b1, 1'b1, 650, 100, 1'b0, 1'b1, 1'b0);
    doFrames(1);
    checkOutput("offscreen_x", 64'(oSpriteVGA[63:54]), 64'd650);
    checkOutput("offscreen_vis", 64'(oSpriteVGA[5]), 64'd0);

    // Update in the same cycle as the vsync fall waits for the following edge
    applyStimulus(1'b0, 1'b0, 1'b1, 300, 100, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    checkOutput("same_edge_held", 64'(oSpriteVGA[63:54]), 64'd650);
    doFrames(1);
    checkOutput("same_edge_next", 64'(oSpriteVGA[63:54]), 64'd300);

    // Animation address stepping and restart
    doReset();
    doFrames(8);
`ifdef ANIM_CYCLE_EN
    checkOutput("anim_8", 64'(oSpriteVGA[25:7]), 64'd4096);
`else
    checkOutput("anim_8", 64'(oSpriteVGA[25:7]), 64'd0);
`endif
    checkOutput("width", 64'(oSpriteVGA[44:35]), 64'd64);
    checkOutput("height", 64'(oSpriteVGA[34:26]), 64'd64);
    doFrames(24);
    checkOutput("anim_32", 64'(oSpriteVGA[25:7]), 64'd0);
    doFrames(8);
    applyStimulus(1'b0, 1'b1, 1'b1, 5, 5, 1'b0, 1'b1, 1'b1);
    doFrames(1);
    checkOutput("anim_restart", 64'(oSpriteVGA[25:7]), 64'd0);

    // Reset while pending drops the update
    applyStimulus(1'b0, 1'b1, 1'b1, 77, 7, 1'b0, 1'b1, 1'b0);
    doReset();
    doFrames(1);
    checkOutput("reset_drop_x", 64'(oSpriteVGA[63:54]), 64'd0);

    // Random traffic against the model
    vs_val = 1'b1;
    vs_left = 10;
    for (int i = 0; i < 3000; i++) begin
      if (vs_left == 0) begin
        vs_val  = !vs_val;
        vs_left = vs_val ? int'($urandom_range(4, 20)) : int'($urandom_range(1, 3));
      end
      vs_left--;
      applyStimulus($urandom_range(0, 399) == 0, vs_val, $urandom_range(0, 9) < 4,
                    int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) == 0);
    end
    idle(1'b1);
    idle(1'b1);
    compare_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_descriptor_writer.md
SPRITE_DESCRIPTOR_WRITER -- requirements
Module: sprite_descriptor_writer

Interface
REQ-001 SHALL have parameter SPRITE_W, default 64, sprite width in pixels (10 b).
REQ-002 SHALL have parameter SPRITE_H, default 64, sprite height in pixels (9 b).
REQ-003 SHALL have parameter BASE_ADDR, default 0, sprite ROM word address of animation frame 0 (19 b).
REQ-004 SHALL have parameter NUM_FRAMES, default 4, number of animation frames (1..16).
REQ-005 SHALL have parameter FRAME_DIV, default 8, VGA frames per animation step (1..255).
REQ-006 iVGA_CLK  in  1  pixel clock; all logic on rising edge; single clock domain.
REQ-007 iRST  in  1  reset, asynchronous, active-high.
REQ-008 iVS  in  1  raw vertical sync from sync generator, active-low.
REQ-009 iUpdValid  in  1  game logic offers a sprite update.
REQ-010 oUpdReady  out  1  block accepts an update this cycle.
REQ-011 iX  in  10  sprite left edge, pixels.
REQ-012 iY  in  9  sprite top edge, pixels.
REQ-013 iFacing  in  1  1 = mirrored (facing left).
REQ-014 iVisible  in  1  sprite drawn when 1.
REQ-015 iAnimRestart  in  1  restart animation at frame 0 on commit.
REQ-016 oSpriteVGA  out  64  descriptor for the VGA controller: [63:54] x, [53:45] y, [44:35] width, [34:26] height, [25:7] ROM base address, [6] facing, [5] visible, [4:0] 0.
REQ-017 oFrameTick  out  1  one-cycle pulse on every commit.

Function
REQ-018 Frame edge SHALL be detected when registered vs_d==1 and iVS==0; commit occurs at that clock edge, with new oSpriteVGA visible the following cycle.
REQ-019 FSM states: IDLE (shadow empty, oUpdReady=1) and PENDING (shadow full, oUpdReady=0).
REQ-020 In IDLE, iUpdValid&&oUpdReady SHALL capture iX, iY, iFacing, iVisible, iAnimRestart into shadow and move to PENDING.
REQ-021 In PENDING, at frame edge the shadow SHALL load oSpriteVGA position/facing/visible fields and the FSM SHALL return to IDLE.
REQ-022 An update accepted in the same cycle as a frame edge SHALL NOT commit at that edge; it commits at the next edge.
REQ-023 oSpriteVGA SHALL change only at frame edges; never mid-frame.
REQ-024 At every frame edge, with or without pending update, anim_div SHALL increment; at FRAME_DIV-1 it wraps to 0 and anim_frame increments modulo NUM_FRAMES.
REQ-025 If committed shadow has iAnimRestart=1, anim_frame and anim_div SHALL both become 0 at that edge (overrides increment).
REQ-026 Base address field SHALL equal (BASE_ADDR + anim_frame*SPRITE_W*SPRITE_H) mod 2^19, using anim_frame value after the edge update.
REQ-027 Width/height fields SHALL be constant SPRITE_W, SPRITE_H.
REQ-028 If committed x>=640 or y>=480, visible bit SHALL be forced 0; x/y fields still loaded unchanged.
REQ-029 oFrameTick SHALL pulse high for exactly one cycle, the cycle after each frame edge.

Reset
REQ-030 iRST high SHALL immediately force: oSpriteVGA=0, oFrameTick=0, FSM=IDLE, shadow=0, anim_frame=0, anim_div=0, vs_d=1.
REQ-031 oUpdReady SHALL be 0 while iRST is high and 1 in the first cycle after release.
REQ-032 Reset during PENDING SHALL discard the pending update; no commit follows.

Configuration
REQ-033 With ANIM_CYCLE_EN defined, animation per REQ-024..REQ-026.
REQ-034 Without ANIM_CYCLE_EN, anim counters SHALL not exist; base address field SHALL be constant BASE_ADDR; iAnimRestart ignored.

Verification
REQ-035 Reset, then iVS held high 100 cycles -> oSpriteVGA=0, oUpdReady=1, oFrameTick never high.
REQ-036 Update x=100,y=200,facing=1,visible=1 mid-frame -> oUpdReady 0 next cycle, oSpriteVGA unchanged until iVS falls, then [63:54]=100,[53:45]=200,[6]=1,[5]=1, oFrameTick one pulse.
REQ-037 Second iUpdValid while PENDING -> not accepted (oUpdReady=0); first update committed, second accepted after commit.
REQ-038 Defaults, ANIM_CYCLE_EN, 8 frame edges -> base address 4096 (frame 1); after 32 edges -> 0 (wrap); commit with iAnimRestart=1 -> 0.
REQ-039 Update x=650,visible=1 -> committed x field 650, visible bit 0.
REQ-040 Update accepted in same cycle as iVS falling edge -> not committed at that edge; committed at next edge.
